// File: rtl/crc16_paket_denetleyici.sv
// crc16_paket_denetleyici: frame sequencer around a byte-wise CRC-16/CCITT-FALSE
// engine. In generate mode it forwards N payload bytes and appends the CRC, MSB
// first. In check mode it forwards the payload, consumes the two trailing CRC
// bytes and flags a mismatch on hata_o.
module crc16_paket_denetleyici #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             baslat_i,
  input  logic             mod_i,
  input  logic [LEN_W-1:0] uzunluk_i,
  input  logic [7:0]       giris_byte_i,
  input  logic             giris_gecerli_i,
  output logic             giris_hazir_o,
  output logic [7:0]       cikis_byte_o,
  output logic             cikis_gecerli_o,
  input  logic             cikis_hazir_i,
  output logic [15:0]      crc_o,
  output logic             mesgul_o,
  output logic             bitti_o,
  output logic             hata_o
);

  typedef enum logic [2:0] {
    BOSTA, VERI, CRC_Y, CRC_D, KONTROL_Y, KONTROL_D, SONUC
  } durum_t;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] BIR       = LEN_W'(1);

  durum_t           durum_q, durum_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] kalan_q, kalan_d;
  logic             mod_q, mod_d;
  logic             hata_q, hata_d;
  logic [7:0]       yuksek_q, yuksek_d;

  // One CRC-16 step over a byte, unrolled bit-serially (poly 0x1021, MSB first).
  function automatic logic [15:0] crc_adim(input logic [15:0] crc,
                                           input logic [7:0]  veri);
    logic [15:0] c;
    c = crc ^ {veri, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Handshake signals: payload pass-through in VERI, CRC bytes out or in afterwards.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    giris_hazir_o   = 1'b0;
    cikis_gecerli_o = 1'b0;
    cikis_byte_o    = 8'h00;
    unique case (durum_q)
      VERI: begin
        giris_hazir_o   = cikis_hazir_i;
        cikis_gecerli_o = giris_gecerli_i;
        cikis_byte_o    = giris_byte_i;
      end
      CRC_Y: begin
        cikis_gecerli_o = 1'b1;
        cikis_byte_o    = crc_q[15:8];
      end
      CRC_D: begin
        cikis_gecerli_o = 1'b1;
        cikis_byte_o    = crc_q[7:0];
      end
      KONTROL_Y, KONTROL_D: giris_hazir_o = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic for the sequencer, CRC register, byte counter and error flag.
  always_comb begin
    durum_d  = durum_q;
    crc_d    = crc_q;
    kalan_d  = kalan_q;
    mod_d    = mod_q;
    hata_d   = hata_q;
    yuksek_d = yuksek_q;
    unique case (durum_q)
      BOSTA: begin
        if (baslat_i) begin
          if (uzunluk_i == '0 || uzunluk_i > MAX_LEN_V) begin
            hata_d  = 1'b1;
            durum_d = SONUC;
          end else begin
            crc_d   = 16'hFFFF;
            kalan_d = uzunluk_i;
            mod_d   = mod_i;
            hata_d  = 1'b0;
            durum_d = VERI;
          end
        end
      end
      VERI: begin
        if (giris_gecerli_i && cikis_hazir_i) begin
          crc_d   = crc_adim(crc_q, giris_byte_i);
          kalan_d = kalan_q - BIR;
          if (kalan_q == BIR) durum_d = mod_q ? KONTROL_Y : CRC_Y;
        end
      end
      CRC_Y: if (cikis_hazir_i) durum_d = CRC_D;
      CRC_D: if (cikis_hazir_i) durum_d = SONUC;
      KONTROL_Y: begin
        if (giris_gecerli_i) begin
          yuksek_d = giris_byte_i;
          durum_d  = KONTROL_D;
        end
      end
      KONTROL_D: begin
        if (giris_gecerli_i) begin
          hata_d  = ({yuksek_q, giris_byte_i} != crc_q);
          durum_d = SONUC;
        end
      end
      SONUC:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  // State register with synchronous reset; reset discards any partial frame.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (rst_i) begin
      durum_q  <= BOSTA;
      crc_q    <= 16'hFFFF;
      kalan_q  <= '0;
      mod_q    <= 1'b0;
      hata_q   <= 1'b0;
      yuksek_q <= 8'h00;
    end else begin
      durum_q  <= durum_d;
      crc_q    <= crc_d;
      kalan_q  <= kalan_d;
      mod_q    <= mod_d;
      hata_q   <= hata_d;
      yuksek_q <= yuksek_d;
    end
  end

  assign crc_o    = crc_q;
  assign mesgul_o = (durum_q != BOSTA);
  assign bitti_o  = (durum_q == SONUC);
  assign hata_o   = hata_q;

endmodule

// File: doc/crc16_paket_denetleyici.md
# crc16_paket_denetleyici

Frame-level sequencer around a byte-wise CRC-16/CCITT-FALSE engine (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR). It sits between a byte source (UART receive path) and a byte sink. It counts a programmed payload length, forwards payload bytes, and runs the CRC over them. In generate mode it appends the CRC (MSB first); in check mode it consumes the two trailing CRC bytes and flags a mismatch.

## Interface
- MAX_LEN, 256: largest legal payload length in bytes.
- LEN_W, 9: width of the length field; must satisfy 2^LEN_W > MAX_LEN.
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- baslat_i  in  1  start pulse; honoured only in BOSTA.
- mod_i  in  1  sampled with baslat_i; 0 = generate/append, 1 = check.
- uzunluk_i  in  LEN_W  payload length N, sampled with baslat_i.
- giris_byte_i  in  8  input byte.
- giris_gecerli_i  in  1  input valid.
- giris_hazir_o  out  1  input ready.
- cikis_byte_o  out  8  output byte.
- cikis_gecerli_o  out  1  output valid.
- cikis_hazir_i  in  1  output ready.
- crc_o  out  16  running/final CRC register.
- mesgul_o  out  1  high in every state except BOSTA.
- bitti_o  out  1  one-cycle frame-done pulse.
- hata_o  out  1  frame error; held until the next accepted baslat_i.

## Operation
- States: BOSTA, VERI, CRC_Y, CRC_D, KONTROL_Y, KONTROL_D, SONUC.
- BOSTA, baslat_i=1, 1<=N<=MAX_LEN:
  - Load crc=0xFFFF and remaining count=N.
  - Latch mode, clear hata_o, go to VERI.
- BOSTA, baslat_i=1, N=0 or N>MAX_LEN: set hata_o=1, go to SONUC, no byte transfers.
- VERI:
  - cikis_byte_o=giris_byte_i, cikis_gecerli_o=giris_gecerli_i, giris_hazir_o=cikis_hazir_i (combinational pass-through).
  - On each handshake (giris_gecerli_i & cikis_hazir_i): crc <= ((crc<<8) ^ T[crc[15:8]^byte]) truncated to 16 bits, where T is the CCITT table (T[0x01]=0x1021, T[0xFF]=0x1EF0); count decrements.
  - Last byte: go to CRC_Y in generate mode, KONTROL_Y in check mode.
- CRC_Y / CRC_D (generate):
  - giris_hazir_o=0, cikis_gecerli_o=1, cikis_byte_o=crc[15:8] then crc[7:0].
  - Each state advances on cikis_hazir_i; CRC_D goes to SONUC.
- KONTROL_Y / KONTROL_D (check):
  - giris_hazir_o=1, cikis_gecerli_o=0; received bytes are not forwarded.
  - KONTROL_Y latches the high byte. KONTROL_D compares {high, low} to crc, sets hata_o on mismatch, and goes to SONUC.
- SONUC: bitti_o=1 for exactly one cycle, then BOSTA.
- crc_o is not modified by the CRC bytes, so it holds the computed payload CRC until the next start.
- baslat_i outside BOSTA is ignored. Input and output are never ready/valid in BOSTA or SONUC.
- Arithmetic:
  - Count width is LEN_W.
  - The CRC update is pure 16-bit combinational XOR/shift; a table ROM or an 8-step bit-serial unroll are both acceptable.

## Timing
- Reset (rst_i=1 at a clock edge) dominates everything, including mid-frame. The cycle after reset:
  - state=BOSTA, crc_o=0xFFFF;
  - giris_hazir_o, cikis_gecerli_o, cikis_byte_o=0x00, mesgul_o, bitti_o, hata_o all 0.
  - A partially processed frame is discarded.
- baslat_i at edge k: mesgul_o=1 and giris_hazir_o may assert from cycle k+1.
- Throughput is one byte per cycle with no stalls. Bubbles are allowed on either side; while cikis_hazir_i=0, cikis_byte_o and cikis_gecerli_o stay stable.
- Latency from the last payload handshake:
  - generate: CRC MSB valid next cycle;
  - check: ready for the CRC MSB next cycle.
- bitti_o asserts the cycle after the final handshake (CRC_D or KONTROL_D), or the cycle after a rejected baslat_i.
- Minimum frame for N bytes with no stalls: N+2 transfer cycles plus one SONUC cycle. A new baslat_i is accepted the cycle after bitti_o.

## Test plan
- Generate, N=9, payload "123456789" (0x31..0x39), sink always ready -> output 0x31..0x39, 0x29, 0xB1; crc_o=0x29B1; one-cycle bitti_o; hata_o=0.
- Check, N=9, same payload:
  - followed by 0x29, 0xB1 -> nothing forwarded after the payload, hata_o=0;
  - repeat with 0x29, 0xB0 -> hata_o=1, crc_o=0x29B1, hata_o held until the next baslat_i.
- Generate, N=1, byte 0x00 -> output 0x00, 0xE1, 0xF0; crc_o=0xE1F0.
- Generate N=9 with random cikis_hazir_i and giris_gecerli_i gaps -> output stream identical to scenario 1, no duplicated or lost bytes, data stable while stalled.
- Length errors:
  - uzunluk_i=0 -> bitti_o one cycle later, hata_o=1, no handshakes;
  - uzunluk_i=MAX_LEN+1 -> same;
  - N=MAX_LEN -> completes normally.
- Reset and ignored start:
  - rst_i after 4 of 9 bytes -> all outputs at reset values, crc_o=0xFFFF; a fresh N=9 "123456789" frame then yields 0x29B1.
  - baslat_i pulsed mid-frame -> ignored, count unaffected.
